// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for datapath load/store traffic. It is a byte-addressed,
// big-endian data store behind valid/ready request and response channels. The
// access latency is programmable, so the datapath can be exercised against a
// memory that stalls.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. A request is accepted only in IDLE. Once
// resp_valid rises, resp_rdata/resp_err stay constant until the edge where
// resp_ready is also 1. resp_ready may already be 1 before the response shows up.
//
// Parameters:
//   DEPTH        number of bytes in the store (power of two)
//   ADDR_W       log2(DEPTH); index bits taken from req_addr
//   WAIT_CYCLES  extra cycles between acceptance and response (0..15)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   req_valid    request present
//   req_ready    responder can accept a request (registered)
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_signed   loads only: 1 sign-extend, 0 zero-extend
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   resp_valid   response present (registered)
//   resp_ready   requester accepts the response
//   resp_rdata   load result extended to 32 bits; 0 for stores and errors
//   resp_err     request was illegal; no memory side effect
//   fsm_state    current FSM state (0 IDLE, 1 WAIT, 2 RESP) for observation
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The counter starts at WAIT_CYCLES-1 and WAIT exits when it reads 0. That
    // gives WAIT_CYCLES cycles in WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

    state_t       state;
    logic [3:0]   cnt;

    // Request fields captured at acceptance.
    logic         lat_we;
    logic [1:0]   lat_size;
    logic         lat_signed;
    logic [31:0]  lat_addr;
    logic [31:0]  lat_wdata;

    // Contents start at zero at power-up and are never touched by reset.
    logic [7:0]   mem [DEPTH] = '{default: 8'h00};

    // ------------------------------------------------------------------
    // Commit-side view of the request. With no wait states the commit edge
    // is the accept edge, so the live request is used. Otherwise the
    // latched copy is used.
    // ------------------------------------------------------------------
    logic         c_we;
    logic [1:0]   c_size;
    logic         c_signed;
    logic [31:0]  c_addr;
    logic [31:0]  c_wdata;
    logic         commit;
    logic         legal;
    logic         mem_we;
    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]   b0, b1, b2, b3;
    logic [31:0]  load_data;
    logic [31:0]  next_rdata;

    always_comb begin
        c_we     = lat_we;
        c_size   = lat_size;
        c_signed = lat_signed;
        c_addr   = lat_addr;
        c_wdata  = lat_wdata;
        if (state == IDLE) begin
            c_we     = req_we;
            c_size   = req_size;
            c_signed = req_signed;
            c_addr   = req_addr;
            c_wdata  = req_wdata;
        end
    end

    assign commit = ((state == IDLE) && req_valid && NO_WAIT) ||
                    ((state == WAIT) && (cnt == 4'd0));

    // Big-endian lanes: the byte at the lowest address is the most significant.
    assign idx0 = c_addr[ADDR_W-1:0];
    assign idx1 = idx0 + ADDR_W'(1);
    assign idx2 = idx0 + ADDR_W'(2);
    assign idx3 = idx0 + ADDR_W'(3);

    assign b0 = mem[idx0];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    always_comb begin
        legal = 1'b0;
        case (c_size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = (c_addr[0] == 1'b0);
            SZ_WORD: legal = (c_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
        // Any address bit above the index range makes the access out of range.
        if ((c_addr >> ADDR_W) != 32'd0) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        load_data = 32'd0;
        case (c_size)
            SZ_BYTE: load_data = c_signed ? {{24{b0[7]}}, b0} : {24'd0, b0};
            SZ_HALF: load_data = c_signed ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
            SZ_WORD: load_data = {b0, b1, b2, b3};
            default: load_data = 32'd0;
        endcase
    end

    assign next_rdata = (legal && !c_we) ? load_data : 32'd0;
    assign mem_we     = commit && legal && c_we;

    // ------------------------------------------------------------------
    // Store port. rst is in the sensitivity list so that a clock edge seen
    // while reset is held never writes. Reset itself does not change the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (rst && mem_we) begin
            case (c_size)
                SZ_BYTE: begin
                    mem[idx0] <= c_wdata[7:0];
                end
                SZ_HALF: begin
                    mem[idx0] <= c_wdata[15:8];
                    mem[idx1] <= c_wdata[7:0];
                end
                default: begin
                    mem[idx0] <= c_wdata[31:24];
                    mem[idx1] <= c_wdata[23:16];
                    mem[idx2] <= c_wdata[15:8];
                    mem[idx3] <= c_wdata[7:0];
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (NO_WAIT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= next_rdata;
                            resp_err   <= ~legal;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= next_rdata;
                        resp_err   <= ~legal;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. One instance uses WAIT_CYCLES=2 and a
// second uses WAIT_CYCLES=0. The two instances share their request inputs.
// sel picks which instance receives req_valid and which one's outputs are
// observed.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rr2, rv2, re2, rr0, rv0, re0;
    logic [31:0] rd2, rd0;
    logic [1:0]  st2, st0;

    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [31:0] o_resp_rdata;
    logic [1:0]  o_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(rr2),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv2), .resp_ready(resp_ready),
        .resp_rdata(rd2), .resp_err(re2), .fsm_state(st2)
    );

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(rr0),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready),
        .resp_rdata(rd0), .resp_err(re0), .fsm_state(st0)
    );

    assign o_req_ready  = sel ? rr0 : rr2;
    assign o_resp_valid = sel ? rv0 : rv2;
    assign o_resp_rdata = sel ? rd0 : rd2;
    assign o_resp_err   = sel ? re0 : re2;
    assign o_state      = sel ? st0 : st2;

    // Driver: run one request through the selected instance.
    // lat = number of cycles from the accept edge until resp_valid is seen
    // (99 if resp_valid never arrives). t_acc = time of the accept edge.
    // When early is set, resp_ready is raised together with req_valid.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic early, output logic [31:0] rdata,
                          output logic err, output int lat, output time t_acc);
        int guard;
        guard = 0;
        while (o_req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; resp_ready = early;
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
        // These fields are don't-care after acceptance, so scramble them.
        req_we = ~we; req_size = 2'b11; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1357_9BDF;
        lat = 1;
        while (o_resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (o_resp_valid !== 1'b1) lat = 99;
        rdata = o_resp_rdata;
        err = o_resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (rr2 !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", rr2); end
        n_cmp++;
        if (rv2 !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", rv2); end
        n_cmp++;
        if (rd2 !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rd2); end
        n_cmp++;
        if (re2 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", re2); end
        n_cmp++;
        if (st2 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", st2); end
        n_cmp++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        if (rr2 !== 1'b1 || rr0 !== 1'b1) begin
            n_bad++; $display("FAIL release_req_ready: got %b/%b expected 1/1", rr2, rr0);
        end
        n_cmp++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; time t;
        do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er, lat, t);
        if (lat !== 3) begin n_bad++; $display("FAIL store_latency: got %0d expected 3", lat); end
        n_cmp++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_bad++; $display("FAIL store_resp: got %h/%b expected 00000000/0", rd, er);
        end
        n_cmp++;
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er, lat, t);
        if (lat !== 3) begin n_bad++; $display("FAIL load_latency: got %0d expected 3", lat); end
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_bad++; $display("FAIL load_word: got %h/%b expected deadbeef/0", rd, er);
        end
        n_cmp++;
    endtask

    task automatic test_endian();
        logic [31:0] addr_t [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
        logic [1:0]  size_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sgn_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_t  [4] = '{32'hFFFF_FFAD, 32'h0000_00AD, 32'hFFFF_BEEF, 32'h0000_BEEF};
        logic [31:0] rd; logic er; int lat; time t;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, size_t[i], sgn_t[i], addr_t[i], 32'd0, 1'b0, rd, er, lat, t);
            if (rd !== exp_t[i] || er !== 1'b0) begin
                n_bad++; $display("FAIL endian_%0d: got %h/%b expected %h/0", i, rd, er, exp_t[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic er; int lat; time t;
        do_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 1'b0, rd, er, lat, t);
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'hDEAD_1234) begin n_bad++; $display("FAIL half_store: got %h expected dead1234", rd); end
        n_cmp++;
        do_txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_007F, 1'b0, rd, er, lat, t);
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'h7FAD_1234) begin n_bad++; $display("FAIL byte_store: got %h expected 7fad1234", rd); end
        n_cmp++;
        do_txn(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'h0000_007F) begin n_bad++; $display("FAIL pos_sign_ext: got %h expected 0000007f", rd); end
        n_cmp++;
    endtask

    task automatic test_errors();
        logic        we_t   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]  size_t [7] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [31:0] addr_t [7] = '{32'h13, 32'h11, 32'h20, 32'h400, 32'h400, 32'h8000_0010, 32'h20};
        logic [31:0] wd_t   [7] = '{32'h0, 32'h0, 32'hAABB_CCDD, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0};
        logic        xerr_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd; logic er; int lat; time t;
        for (int i = 0; i < 7; i++) begin
            do_txn(we_t[i], size_t[i], 1'b0, addr_t[i], wd_t[i], 1'b0, rd, er, lat, t);
            if (rd !== 32'd0 || er !== xerr_t[i]) begin
                n_bad++; $display("FAIL error_%0d: got %h/%b expected 00000000/%b", i, rd, er, xerr_t[i]);
            end
            n_cmp++;
        end
        // Rejected stores to 0x400 and 0x80000010 must not alias onto low addresses.
        do_txn(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'd0) begin n_bad++; $display("FAIL alias_0: got %h expected 00000000", rd); end
        n_cmp++;
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'h7FAD_1234) begin n_bad++; $display("FAIL alias_10: got %h expected 7fad1234", rd); end
        n_cmp++;
    endtask

    task automatic test_boundary();
        logic [31:0] rd; logic er; int lat; time t;
        do_txn(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D, 1'b0, rd, er, lat, t);
        if (er !== 1'b0) begin n_bad++; $display("FAIL top_store_err: got %b expected 0", er); end
        n_cmp++;
        do_txn(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL top_word: got %h expected cafef00d", rd); end
        n_cmp++;
        do_txn(1'b0, 2'b00, 1'b0, 32'h3FF, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'h0000_000D) begin n_bad++; $display("FAIL top_byte: got %h expected 0000000d", rd); end
        n_cmp++;
    endtask

    task automatic test_backpressure();
        int guard;
        sel = 1'b0;
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (rv2 !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            req_addr = 32'h3FC; req_size = 2'b00; req_we = 1'b1;
            if (rv2 !== 1'b1 || rd2 !== 32'h7FAD_1234 || re2 !== 1'b0 || rr2 !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_%0d: got v=%b d=%h e=%b r=%b expected v=1 d=7fad1234 e=0 r=0",
                         i, rv2, rd2, re2, rr2);
            end
            n_cmp++;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (rv2 !== 1'b0 || rr2 !== 1'b1 || rd2 !== 32'd0 || re2 !== 1'b0 || st2 !== 2'd0) begin
            n_bad++;
            $display("FAIL release: got v=%b r=%b d=%h e=%b s=%0d expected v=0 r=1 d=0 e=0 s=0",
                     rv2, rr2, rd2, re2, st2);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a, rd_b; logic er_a, er_b; int lat_a, lat_b; time t_a, t_b;
        do_txn(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 1'b1, rd_a, er_a, lat_a, t_a);
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, rd_b, er_b, lat_b, t_b);
        if (t_b - t_a != 40) begin n_bad++; $display("FAIL b2b_spacing: got %0t expected 40", t_b - t_a); end
        n_cmp++;
        if (rd_a !== 32'hCAFE_F00D || rd_b !== 32'h7FAD_1234 || lat_a !== 3 || lat_b !== 3) begin
            n_bad++;
            $display("FAIL b2b_data: got %h %h lat %0d %0d expected cafef00d 7fad1234 lat 3 3",
                     rd_a, rd_b, lat_a, lat_b);
        end
        n_cmp++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd_a, rd_b; logic er_a, er_b; int lat_a, lat_b; time t_a, t_b;
        sel = 1'b1;
        do_txn(1'b1, 2'b10, 1'b0, 32'h0, 32'h0102_0304, 1'b0, rd_a, er_a, lat_a, t_a);
        if (lat_a !== 1) begin n_bad++; $display("FAIL zw_store_latency: got %0d expected 1", lat_a); end
        n_cmp++;
        do_txn(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 1'b1, rd_a, er_a, lat_a, t_a);
        do_txn(1'b0, 2'b01, 1'b1, 32'h2, 32'd0, 1'b1, rd_b, er_b, lat_b, t_b);
        if (lat_a !== 1 || lat_b !== 1) begin
            n_bad++; $display("FAIL zw_load_latency: got %0d %0d expected 1 1", lat_a, lat_b);
        end
        n_cmp++;
        if (rd_a !== 32'h0102_0304 || rd_b !== 32'h0000_0304) begin
            n_bad++; $display("FAIL zw_data: got %h %h expected 01020304 00000304", rd_a, rd_b);
        end
        n_cmp++;
        if (t_b - t_a != 20) begin n_bad++; $display("FAIL zw_spacing: got %0t expected 20", t_b - t_a); end
        n_cmp++;
        sel = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; time t; int guard;
        sel = 1'b0;
        // Reset while in WAIT: the store is discarded.
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h5555_5555;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (st2 !== 2'd1) begin n_bad++; $display("FAIL midop_in_wait: got %0d expected 1", st2); end
        n_cmp++;
        rst = 1'b0;
        #1;
        if (rr2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 32'd0 || re2 !== 1'b0 || st2 !== 2'd0) begin
            n_bad++;
            $display("FAIL midop_clear: got r=%b v=%b d=%h e=%b s=%0d expected r=1 v=0 d=0 e=0 s=0",
                     rr2, rv2, rd2, re2, st2);
        end
        n_cmp++;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        do_txn(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_bad++; $display("FAIL wait_reset_mem: got %h/%b expected 00000000/0", rd, er);
        end
        n_cmp++;
        // Reset while in RESP: the store has already been committed and must remain.
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h34; req_wdata = 32'hA5A5_A5A5;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (rv2 !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
        rst = 1'b0;
        #1;
        if (rv2 !== 1'b0 || rr2 !== 1'b1) begin
            n_bad++; $display("FAIL resp_reset_drop: got v=%b r=%b expected v=0 r=1", rv2, rr2);
        end
        n_cmp++;
        @(negedge clk); rst = 1'b1;
        do_txn(1'b0, 2'b10, 1'b0, 32'h34, 32'd0, 1'b0, rd, er, lat, t);
        if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL resp_reset_mem: got %h expected a5a5a5a5", rd); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_endian();
        test_partial();
        test_errors();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_zero_wait();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
